keypad_hex_entry: RTL and testbench

Scans a 4x4 matrix hex keypad by driving columns low one at a time and reading the active-low row lines. Each press is debounced and decoded to a 4-bit hex code. Two accepted digits are packed into an 8-bit operand, high nibble first, for the arithmetic datapath. This is the input-side counterpart of the multiplexed seven-segment output path: the display turns hex into a multiplexed drive, and this block turns a multiplexed scan back into hex.

---
 rtl/keypad_if.sv | 24 ++
 rtl/keypad_hex_entry.sv | 201 ++++++++++++++++++++
 tb/tb_keypad_hex_entry.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/keypad_if.sv
// Keypad scanner bus: matrix rows/columns, clear, decoded key and operand.
`timescale 1ns/1ps
interface keypad_if;
  logic [3:0] row;
  logic       clear;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;
  logic [7:0] operand;
  logic       operand_valid;

  modport master (
    output row, clear,
    input  col, key_code, key_valid,
    input  key_down, operand, operand_valid
  );

  modport slave (
    input  row, clear,
    output col, key_code, key_valid,
    output key_down, operand, operand_valid
  );
endinterface

// File: rtl/keypad_hex_entry.sv
// 4x4 hex keypad scanner, debouncer and two-digit operand packer.
// Define KEYPAD_GHOST_REJECT_EN to reject multi-key scans instead of taking the lowest code.
`timescale 1ns/1ps
module keypad_hex_entry #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input logic     clk,
  input logic     rst,
  keypad_if.slave kp
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {
    IDLE, DEBOUNCE, HELD, RELEASE
  } state_t;

  state_t          state, state_n;
  logic [3:0]      row_m, row_s;
  logic [SW-1:0]   slot;
  logic [1:0]      col_idx;
  logic [2:0][3:0] hits;
  logic            slot_end, scan_done;
  logic [15:0]     map;
  logic            any, multi, is_key;
  logic [3:0]      code;
  logic [3:0]      cand, cand_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            accept, down;
  logic [3:0]      key_code_q;
  logic            key_valid_q, op_valid_q;
  logic [7:0]      operand_q;
  logic            digit;

  assign slot_end  = (slot == SW'(SCAN_DIV - 1));
  assign scan_done = slot_end && (col_idx == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_m   <= 4'b1111;
      row_s   <= 4'b1111;
      slot    <= '0;
      col_idx <= 2'd0;
      hits    <= '0;
    end else begin
      row_m <= kp.row;
      row_s <= row_m;
      if (slot_end) begin
        slot    <= '0;
        col_idx <= col_idx + 2'd1;
        unique case (col_idx)
          2'd0: hits[0] <= ~row_s;
          2'd1: hits[1] <= ~row_s;
          2'd2: hits[2] <= ~row_s;
          default: ;
        endcase
      end else begin
        slot <= slot + SW'(1);
      end
    end
  end

  assign kp.col = ~(4'b0001 << col_idx);

  // Column 3 is taken live from the synchronizer on the deciding cycle
  always_comb begin
    map  = '0;
    code = 4'd0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        map[r*4+c] = hits[c][r];
      end
      map[r*4+3] = ~row_s[r];
    end
    for (int i = 15; i >= 0; i--) begin
      if (map[i]) code = 4'(i);
    end
  end

  assign any   = |map;
  assign multi = |(map & (map - 16'd1));
`ifdef KEYPAD_GHOST_REJECT_EN
  assign is_key = any && !multi;
`else
  assign is_key = any;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cand  <= 4'd0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cand  <= cand_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    if (scan_done) begin
      unique case (state)
        IDLE: begin
          if (is_key) begin
            cand_n = code;
            if (DEBOUNCE_SCANS == 1) begin
              state_n = HELD;
              cnt_n   = '0;
            end else begin
              state_n = DEBOUNCE;
              cnt_n   = CW'(1);
            end
          end
        end
        DEBOUNCE: begin
          if (is_key && code == cand) begin
            if (cnt == CW'(DEBOUNCE_SCANS - 1)) begin
              state_n = HELD;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end else if (is_key) begin
            cand_n = code;
            cnt_n  = CW'(1);
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
        // Only a truly empty scan starts a release; rejected ghosts are ignored
        HELD: begin
          if (!any) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_n = IDLE;
              cnt_n   = '0;
            end else begin
              state_n = RELEASE;
              cnt_n   = CW'(1);
            end
          end
        end
        RELEASE: begin
          if (!is_key) begin
            if (cnt == CW'(DEBOUNCE_SCANS - 1)) begin
              state_n = IDLE;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end else begin
            state_n = HELD;
            cnt_n   = '0;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_comb begin
    down   = (state == HELD) || (state == RELEASE);
    accept = scan_done && !down && (state_n == HELD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      op_valid_q  <= 1'b0;
      operand_q   <= 8'd0;
      digit       <= 1'b0;
    end else begin
      key_valid_q <= accept;
      op_valid_q  <= accept && digit && !kp.clear;
      if (accept) key_code_q <= cand_n;
      if (kp.clear) begin
        operand_q <= 8'd0;
        digit     <= 1'b0;
      end else if (accept) begin
        operand_q <= {operand_q[3:0], cand_n};
        digit     <= ~digit;
      end
    end
  end

  assign kp.key_code      = key_code_q;
  assign kp.key_valid     = key_valid_q;
  assign kp.key_down      = down;
  assign kp.operand       = operand_q;
  assign kp.operand_valid = op_valid_q;

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Randomized keypad bench with a scan-level reference model.
// Honours KEYPAD_GHOST_REJECT_EN in the model as well.
`timescale 1ns/1ps
module tb_keypad_hex_entry;
  localparam int SD = 4;
  localparam int DS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pressed = '0;
  int          checks = 0;
  int          fails  = 0;

  always #5 clk = ~clk;

  keypad_if kif();

  keypad_hex_entry #(
    .SCAN_DIV(SD),
    .DEBOUNCE_SCANS(DS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp(kif.slave)
  );

  always_comb begin
    kif.row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kif.col[c]) kif.row[r] = 1'b0;
  end

  bit         m_down;
  int         m_cnt, m_cand, m_rel;
  logic [7:0] m_op;
  bit         m_dig;
  logic       e_kv, e_ov, e_down;
  logic [3:0] e_code;
  logic [7:0] e_op;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_down = 0; m_cnt = 0; m_cand = 0; m_rel = 0;
    m_op = 8'h00; m_dig = 0;
    e_kv = 0; e_ov = 0; e_down = 0;
    e_code = 4'h0; e_op = 8'h00;
  endtask

  task automatic model_scan(input logic [15:0] mask, input bit clr);
    int  n, low;
    bit  any, iskey, acc;
    n   = $countones(mask);
    any = (n > 0);
    low = 0;
    for (int i = 15; i >= 0; i--) if (mask[i]) low = i;
`ifdef KEYPAD_GHOST_REJECT_EN
    iskey = (n == 1);
`else
    iskey = any;
`endif
    acc = 0;
    if (!m_down) begin
      if (iskey) begin
        if (m_cnt > 0 && low == m_cand) m_cnt++;
        else begin m_cand = low; m_cnt = 1; end
        if (m_cnt >= DS) begin
          acc = 1; m_down = 1; m_cnt = 0; m_rel = 0;
        end
      end else begin
        m_cnt = 0;
      end
    end else begin
      if (!any || (!iskey && m_rel > 0)) begin
        m_rel++;
        if (m_rel >= DS) begin m_down = 0; m_rel = 0; end
      end else if (iskey) begin
        m_rel = 0;
      end
    end
    e_kv = acc;
    e_ov = 0;
    if (acc) begin
      e_code = 4'(low);
      if (clr) begin
        m_op = 8'h00; m_dig = 0;
      end else begin
        e_ov  = m_dig;
        m_op  = {m_op[3:0], 4'(low)};
        m_dig = !m_dig;
      end
    end else if (clr) begin
      m_op = 8'h00; m_dig = 0;
    end
    e_op   = m_op;
    e_down = m_down;
  endtask

  task automatic run_scan(input logic [15:0] mask, input bit clr);
    logic [3:0] ec;
    pressed = mask;
    for (int i = 0; i < 4 * SD; i++) begin
      ec = ~(4'b0001 << (i / SD));
      chk("col", kif.col, ec);
      if (i == 0) begin
        chk("key_valid", kif.key_valid, e_kv);
        chk("operand_valid", kif.operand_valid, e_ov);
        chk("key_code", kif.key_code, e_code);
        chk("operand", kif.operand, e_op);
        chk("key_down", kif.key_down, e_down);
      end
      if (i == 1) begin
        chk("kv_one_cycle", kif.key_valid, 1'b0);
        chk("ov_one_cycle", kif.operand_valid, 1'b0);
      end
      if (i == 4 * SD - 1) kif.clear = clr;
      @(posedge clk);
      #1;
      kif.clear = 1'b0;
    end
    model_scan(mask, clr);
  endtask

  task automatic press(input int k, input int n);
    for (int s = 0; s < n; s++) run_scan(16'(1) << k, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int s = 0; s < n; s++) run_scan(16'h0000, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pressed = '0;
    kif.clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_col", kif.col, 4'b1110);
    chk("rst_kv", kif.key_valid, 1'b0);
    chk("rst_down", kif.key_down, 1'b0);
    chk("rst_operand", kif.operand, 8'h00);
    chk("rst_ov", kif.operand_valid, 1'b0);
    chk("rst_code", kif.key_code, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int kind, dur, k1, k2;
    logic [15:0] m;
    kif.clear = 1'b0;
    model_reset();
    do_reset();
    idle(2);

    press(9, 5);
    idle(3);

    press(3, 1);
    idle(1);
    press(3, 3);
    idle(3);

    press(10, 3); idle(3);
    press(5, 3);  idle(3);
    press(7, 3);  idle(3);

    run_scan(16'h4000, 1'b0);
    run_scan(16'h4000, 1'b1);
    press(14, 1);
    idle(3);
    press(1, 3); idle(3);
    press(2, 3); idle(3);

    run_scan(16'h0041, 1'b0);
    run_scan(16'h0041, 1'b0);
    run_scan(16'h0041, 1'b0);
    idle(3);

    press(11, 1);
    pressed = 16'h0800;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_col", kif.col, 4'b1110);
    chk("mid_rst_down", kif.key_down, 1'b0);
    do_reset();
    press(11, 3);
    idle(3);

    for (int seg = 0; seg < 60; seg++) begin
      kind = $urandom_range(0, 7);
      dur  = $urandom_range(1, 4);
      k1   = $urandom_range(0, 15);
      k2   = $urandom_range(0, 15);
      m = '0;
      if (kind <= 4) m[k1] = 1'b1;
      else if (kind == 7) begin m[k1] = 1'b1; m[k2] = 1'b1; end
      for (int s = 0; s < dur; s++)
        run_scan(m, ($urandom_range(0, 7) == 0));
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
